ipsxb_fft_job_sched: RTL and testbench
======================================

Name: ipsxb_fft_job_sched

Overview:
- Frame-level round-robin scheduler that shares one FFT IP core between NUM_REQ AXI4-Stream sources.
- Sequence per job:
  - grants one requester for exactly one frame;
  - issues a one-beat config (FFT/IFFT mode) to the core;
  - forwards 2^LOGS_FFT_LEN data beats, generating tlast itself;
  - repairs length mismatches by zero-padding short frames and draining long ones.
- Sits between the frame sources (test frame generator, capture path) and the FFT IP input side.

Parameters:
NUM_REQ, 2, number of requesters (2..4).
LOGS_FFT_LEN, 4, log2 of FFT length N.
INPUT_WIDTH, 16, real/imag sample width; DATAIN_WIDTH = INPUT_WIDTH rounded up to a multiple of 8 (localparam); one beat = 2*DATAIN_WIDTH bits, {im,re}.

Ports:
i_aclk  in  1  clock
i_areset  in  1  synchronous active-high reset
i_aclken  in  1  clock enable; all state, counters and handshakes qualify on it
i_req_tvalid  in  NUM_REQ  per-source valid
o_req_tready  out  NUM_REQ  per-source ready
i_req_tdata  in  NUM_REQ*2*DATAIN_WIDTH  per-source data, source k at slice k
i_req_tlast  in  NUM_REQ  per-source frame end
i_req_mode  in  NUM_REQ  1=FFT, 0=IFFT; sampled at grant
o_axi4s_cfg_tvalid  out  1  core config strobe
o_axi4s_cfg_tdata  out  1  core mode
o_axi4s_data_tvalid  out  1  core data valid
o_axi4s_data_tdata  out  2*DATAIN_WIDTH  core data
o_axi4s_data_tlast  out  1  core frame end
i_axi4s_data_tready  in  1  core ready
o_grant_id  out  max(1,clog2(NUM_REQ))  current/last granted source
o_busy  out  1  state != IDLE
o_len_err  out  1  one-enabled-cycle pulse on length mismatch
o_frame_cnt  out  16  completed frames, wraps at 2^16

Behaviour:
- Transfer definitions:
  - source beat = i_aclken & i_req_tvalid[g] & o_req_tready[g];
  - core beat = i_aclken & o_axi4s_data_tvalid & i_axi4s_data_tready.
- Reset (i_areset=1, sampled on i_aclk regardless of i_aclken):
  - state IDLE; RR pointer 0; beat counter 0; o_frame_cnt 0; o_grant_id 0;
  - all valid, ready, tlast, cfg and err outputs 0; o_axi4s_cfg_tdata 1.
  - Reset mid-frame abandons the frame; no tlast is emitted.
- States: IDLE, CFG, DATA, PAD, DRAIN. Transitions occur only on enabled cycles.
- IDLE:
  - If any i_req_tvalid is set, grant the first set bit searching from the RR pointer upward, with wrap.
  - Latch g, latch mode = i_req_mode[g], go to CFG.
  - Same-cycle contention is resolved purely by the pointer.
- CFG:
  - o_axi4s_cfg_tvalid = 1 for exactly one enabled cycle, with tdata = latched mode.
  - Go to DATA; beat counter = 0.
- DATA (combinational pass-through):
  - o_axi4s_data_tvalid = i_req_tvalid[g];
  - o_req_tready[g] = i_axi4s_data_tready; other readies 0;
  - tdata = source slice g;
  - o_axi4s_data_tlast = (counter == N-1).
  - Each core beat increments the counter.
  - Beat N-1 with source tlast: frame complete, go to IDLE.
  - Beat N-1 without source tlast: pulse o_len_err, go to DRAIN.
  - Source tlast on a beat < N-1: pulse o_len_err, go to PAD.
- PAD:
  - o_req_tready = 0; o_axi4s_data_tvalid = 1; tdata = 0.
  - Counter continues; tlast at N-1; the core beat at N-1 completes the frame, go to IDLE.
- DRAIN:
  - o_req_tready[g] = 1; o_axi4s_data_tvalid = 0.
  - Discard source beats until a source beat with tlast, then go to IDLE (frame already counted).
- Frame complete (core beat carrying tlast):
  - o_frame_cnt increments.
  - RR pointer = g+1, wrapping to 0 past NUM_REQ-1.
- In IDLE and CFG all o_req_tready = 0; core tvalid = 0.
- Latency: grant to first forwardable beat is 2 enabled cycles (IDLE→CFG→DATA).
- o_grant_id holds the last grant in IDLE.
- Counter width is LOGS_FFT_LEN; it wraps to 0 after N-1.

Test Plan:
- Req0 only, mode=1, 16 beats, tlast on beat 16, tready=1, aclken=1 → one cfg_tvalid pulse with tdata=1; 16 core beats identical to source; core tlast on beat 16 only; len_err never set; frame_cnt=1.
- Req0 and req1 both continuously valid, 4 frames each → grant sequence 0,1,0,1…; frame_cnt=8; cfg_tdata follows each source's mode.
- Req1 tlast on beat 10 → core beats 11–16 carry data 0 with o_req_tready[1]=0; core tlast on beat 16; one len_err pulse; frame_cnt+1.
- Req0 sends 20 beats, tlast on beat 20 → 16 beats forwarded; beats 17–20 accepted with core tvalid=0; one len_err pulse; next grant only after beat 20.
- aclken high 1 cycle in 2, core tready toggling → frame identical to the aclken=1 case; no beat duplicated or dropped; cfg_tvalid high for exactly one enabled cycle.
- Reset asserted at beat 7 of a frame → next clock: all outputs 0, busy=0, frame_cnt=0; after release, a new frame from req0 starts with cfg, and the pointer starts at 0.

Source files
------------

// File: rtl/ipsxb_fft_job_sched.sv
// Frame-level round-robin scheduler that shares one FFT core between NUM_REQ
// AXI4-Stream sources: one mode config beat, then exactly 2^LOGS_FFT_LEN data beats per grant.
module ipsxb_fft_job_sched #(
    parameter int NUM_REQ      = 2,
    parameter int LOGS_FFT_LEN = 4,
    parameter int INPUT_WIDTH  = 16,
    localparam int DATAIN_WIDTH = ((INPUT_WIDTH + 7) / 8) * 8,
    localparam int BEAT_W       = 2 * DATAIN_WIDTH,
    localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      i_aclk,
    input  logic                      i_areset,
    input  logic                      i_aclken,
    input  logic [NUM_REQ-1:0]        i_req_tvalid,
    output logic [NUM_REQ-1:0]        o_req_tready,
    input  logic [NUM_REQ*BEAT_W-1:0] i_req_tdata,
    input  logic [NUM_REQ-1:0]        i_req_tlast,
    input  logic [NUM_REQ-1:0]        i_req_mode,
    output logic                      o_axi4s_cfg_tvalid,
    output logic                      o_axi4s_cfg_tdata,
    output logic                      o_axi4s_data_tvalid,
    output logic [BEAT_W-1:0]         o_axi4s_data_tdata,
    output logic                      o_axi4s_data_tlast,
    input  logic                      i_axi4s_data_tready,
    output logic [GW-1:0]             o_grant_id,
    output logic                      o_busy,
    output logic                      o_len_err,
    output logic [15:0]               o_frame_cnt
);

    typedef enum logic [2:0] {IDLE, CFG, DATA, PAD, DRAIN} state_t;

    localparam logic [LOGS_FFT_LEN-1:0] LAST_IDX = '1;

    state_t                  state, state_nxt;
    logic [GW-1:0]           grant, rr_ptr, pick;
    logic                    pick_vld;
    logic                    mode;
    logic [LOGS_FFT_LEN-1:0] cnt;
    logic [15:0]             frame_cnt;
    logic                    src_tvalid, src_tlast;
    logic [BEAT_W-1:0]       src_tdata;
    logic                    core_beat, src_beat, at_last, len_err;
    int                      off, best_off;

    // Winner is the valid requester with the smallest distance above the pointer.
    always_comb begin
        pick     = rr_ptr;
        best_off = NUM_REQ;
        off      = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            off = (j >= int'(rr_ptr)) ? j - int'(rr_ptr) : j + NUM_REQ - int'(rr_ptr);
            if (i_req_tvalid[j] && off < best_off) begin
                best_off = off;
                pick     = GW'(j);
            end
        end
    end

    assign pick_vld = |i_req_tvalid;

    always_comb begin
        src_tdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant == GW'(j)) begin
                src_tdata = i_req_tdata[j*BEAT_W +: BEAT_W];
            end
        end
    end

    assign src_tvalid = i_req_tvalid[grant];
    assign src_tlast  = i_req_tlast[grant];
    assign at_last    = (cnt == LAST_IDX);

    always_comb begin
        o_req_tready        = '0;
        o_axi4s_data_tvalid = 1'b0;
        o_axi4s_data_tdata  = '0;
        o_axi4s_data_tlast  = 1'b0;
        case (state)
            DATA: begin
                o_req_tready[grant] = i_axi4s_data_tready;
                o_axi4s_data_tvalid = src_tvalid;
                o_axi4s_data_tdata  = src_tdata;
                o_axi4s_data_tlast  = at_last;
            end
            PAD: begin
                o_axi4s_data_tvalid = 1'b1;
                o_axi4s_data_tlast  = at_last;
            end
            DRAIN: o_req_tready[grant] = 1'b1;
            default: ;
        endcase
    end

    assign core_beat = i_aclken & o_axi4s_data_tvalid & i_axi4s_data_tready;
    assign src_beat  = i_aclken & src_tvalid & o_req_tready[grant];

    always_comb begin
        state_nxt = state;
        len_err   = 1'b0;
        case (state)
            IDLE: if (pick_vld) state_nxt = CFG;
            CFG:  state_nxt = DATA;
            DATA: begin
                if (core_beat) begin
                    if (at_last) begin
                        state_nxt = src_tlast ? IDLE : DRAIN;
                        len_err   = !src_tlast;
                    end else if (src_tlast) begin
                        state_nxt = PAD;
                        len_err   = 1'b1;
                    end
                end
            end
            PAD:   if (core_beat && at_last) state_nxt = IDLE;
            DRAIN: if (src_beat && src_tlast) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_aclk) begin
        if (i_areset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            cnt       <= '0;
            frame_cnt <= '0;
            grant     <= '0;
            mode      <= 1'b1;
        end else if (i_aclken) begin
            state <= state_nxt;
            if (state == IDLE && pick_vld) begin
                grant <= pick;
                mode  <= i_req_mode[pick];
            end
            if (state == CFG) begin
                cnt <= '0;
            end else if (core_beat) begin
                cnt <= cnt + 1'b1;
            end
            // The core beat carrying tlast closes the frame, even if the source overruns.
            if (core_beat && at_last) begin
                frame_cnt <= frame_cnt + 16'd1;
                rr_ptr    <= (grant == GW'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    assign o_axi4s_cfg_tvalid = (state == CFG);
    assign o_axi4s_cfg_tdata  = mode;
    assign o_grant_id         = grant;
    assign o_busy             = (state != IDLE);
    assign o_len_err          = len_err;
    assign o_frame_cnt        = frame_cnt;

endmodule

// File: tb/tb_ipsxb_fft_job_sched.sv
// Directed bench for ipsxb_fft_job_sched: two sources, N=16, 16-bit samples.
module tb_ipsxb_fft_job_sched;
    localparam int NREQ = 2;
    localparam int BW   = 32;
    localparam int N    = 16;

    logic               clk = 1'b0;
    logic               i_areset, i_aclken;
    logic [NREQ-1:0]    i_req_tvalid, o_req_tready, i_req_tlast, i_req_mode;
    logic [NREQ*BW-1:0] i_req_tdata;
    logic               o_axi4s_cfg_tvalid, o_axi4s_cfg_tdata;
    logic               o_axi4s_data_tvalid, o_axi4s_data_tlast, i_axi4s_data_tready;
    logic [BW-1:0]      o_axi4s_data_tdata;
    logic [0:0]         o_grant_id;
    logic               o_busy, o_len_err;
    logic [15:0]        o_frame_cnt;

    ipsxb_fft_job_sched #(.NUM_REQ(2), .LOGS_FFT_LEN(4), .INPUT_WIDTH(16)) dut (
        .i_aclk(clk), .i_areset(i_areset), .i_aclken(i_aclken),
        .i_req_tvalid(i_req_tvalid), .o_req_tready(o_req_tready),
        .i_req_tdata(i_req_tdata), .i_req_tlast(i_req_tlast), .i_req_mode(i_req_mode),
        .o_axi4s_cfg_tvalid(o_axi4s_cfg_tvalid), .o_axi4s_cfg_tdata(o_axi4s_cfg_tdata),
        .o_axi4s_data_tvalid(o_axi4s_data_tvalid), .o_axi4s_data_tdata(o_axi4s_data_tdata),
        .o_axi4s_data_tlast(o_axi4s_data_tlast), .i_axi4s_data_tready(i_axi4s_data_tready),
        .o_grant_id(o_grant_id), .o_busy(o_busy), .o_len_err(o_len_err),
        .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cfg_cnt, beat_cnt, tlast_cnt, err_cnt, drain_cnt, bad_ready;
    logic run_ok;
    int grants[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Source beat payload: tag nibble, source id, frame number, 1-based beat index.
    function automatic logic [31:0] mkdata(input int s, input int f, input int k);
        logic [15:0] kk;
        kk = k[15:0] + 16'd1;
        return {4'hA, s[3:0], f[7:0], kk};
    endfunction

    task automatic run(input int nf0, input int l0, input int nf1, input int l1,
                       input logic m0, input logic m1, input bit en_tog, input bit rdy_tog,
                       input int abort_at);
        int nf[2], len[2], k[2], fr[2], mon_fr[2];
        logic md[2], sb[2];
        int c_idx, cur, cyc;
        bit done;
        logic [31:0] exp_d;
        nf[0] = nf0; nf[1] = nf1; len[0] = l0; len[1] = l1; md[0] = m0; md[1] = m1;
        for (int s = 0; s < 2; s++) begin
            k[s] = 0; fr[s] = 0; mon_fr[s] = 0; sb[s] = 1'b0;
        end
        cfg_cnt = 0; beat_cnt = 0; tlast_cnt = 0; err_cnt = 0; drain_cnt = 0; bad_ready = 0;
        grants.delete();
        run_ok = 1'b0;
        c_idx = 0; cur = 0; cyc = 0; done = 1'b0;
        i_req_mode = {m1, m0};
        i_aclken = 1'b1;
        i_axi4s_data_tready = 1'b1;
        while (!done) begin
            for (int s = 0; s < 2; s++) begin
                i_req_tvalid[s]         = (fr[s] < nf[s]);
                i_req_tdata[s*BW +: BW] = mkdata(s, fr[s], k[s]);
                i_req_tlast[s]          = (k[s] == len[s] - 1);
            end
            @(negedge clk);
            if (i_aclken && o_axi4s_cfg_tvalid) begin
                cfg_cnt++;
                cur = int'(o_grant_id);
                grants.push_back(cur);
                c_idx = 0;
                check("cfg_mode", 32'(o_axi4s_cfg_tdata), 32'(md[cur]));
            end
            if ((!o_busy || o_axi4s_cfg_tvalid) && |o_req_tready) bad_ready++;
            for (int s = 0; s < 2; s++) begin
                if (s != int'(o_grant_id) && o_req_tready[s]) bad_ready++;
                sb[s] = i_aclken && i_req_tvalid[s] && o_req_tready[s];
            end
            if (i_aclken && o_axi4s_data_tvalid && i_axi4s_data_tready) begin
                beat_cnt++;
                exp_d = (c_idx < len[cur]) ? mkdata(cur, mon_fr[cur], c_idx) : 32'd0;
                if (c_idx >= len[cur] && o_req_tready[cur]) bad_ready++;
                check("core_data", o_axi4s_data_tdata, exp_d);
                check("core_tlast", 32'(o_axi4s_data_tlast), 32'(c_idx == N - 1));
                if (o_axi4s_data_tlast) begin
                    tlast_cnt++;
                    mon_fr[cur]++;
                end
                c_idx++;
            end
            if (sb[cur] && !o_axi4s_data_tvalid) drain_cnt++;
            if (o_len_err) err_cnt++;
            @(posedge clk);
            #1;
            for (int s = 0; s < 2; s++) begin
                if (sb[s]) begin
                    k[s]++;
                    if (k[s] == len[s]) begin
                        k[s] = 0;
                        fr[s]++;
                    end
                end
            end
            cyc++;
            if (en_tog) i_aclken = ~i_aclken;
            if (rdy_tog) i_axi4s_data_tready = (cyc % 3 != 2);
            if (abort_at > 0 && beat_cnt >= abort_at) begin
                done = 1'b1; run_ok = 1'b1;
            end else if (fr[0] >= nf[0] && fr[1] >= nf[1] && !o_busy) begin
                done = 1'b1; run_ok = 1'b1;
            end else if (cyc >= 1000) begin
                done = 1'b1;
            end
        end
        for (int s = 0; s < 2; s++) begin
            i_req_tvalid[s]         = (fr[s] < nf[s]);
            i_req_tdata[s*BW +: BW] = mkdata(s, fr[s], k[s]);
            i_req_tlast[s]          = (k[s] == len[s] - 1);
        end
        check("run_done", 32'(run_ok), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},       32'(o_busy), 32'd0);
        check({tag, "_frame_cnt"},  32'(o_frame_cnt), 32'd0);
        check({tag, "_grant"},      32'(o_grant_id), 32'd0);
        check({tag, "_cfg_tvalid"}, 32'(o_axi4s_cfg_tvalid), 32'd0);
        check({tag, "_cfg_tdata"},  32'(o_axi4s_cfg_tdata), 32'd1);
        check({tag, "_dvalid"},     32'(o_axi4s_data_tvalid), 32'd0);
        check({tag, "_dlast"},      32'(o_axi4s_data_tlast), 32'd0);
        check({tag, "_tready"},     32'(o_req_tready), 32'd0);
        check({tag, "_len_err"},    32'(o_len_err), 32'd0);
    endtask

    initial begin
        i_areset = 1'b1; i_aclken = 1'b0;
        i_req_tvalid = '0; i_req_tdata = '0; i_req_tlast = '0; i_req_mode = '0;
        i_axi4s_data_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        i_areset = 1'b0;

        // Single FFT frame from source 0 with exact length.
        run(1, 16, 0, 16, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("s1_cfg", cfg_cnt, 1);
        check("s1_beats", beat_cnt, 16);
        check("s1_tlast", tlast_cnt, 1);
        check("s1_err", err_cnt, 0);
        check("s1_ready", bad_ready, 0);
        check("s1_grant", (grants.size() > 0) ? grants[0] : -1, 0);
        check("s1_frames", 32'(o_frame_cnt), 1);

        // Contention; pointer is 1 after source 0 completed, so source 1 wins first.
        run(4, 16, 4, 16, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("s2_cfg", cfg_cnt, 8);
        check("s2_beats", beat_cnt, 128);
        check("s2_tlast", tlast_cnt, 8);
        check("s2_err", err_cnt, 0);
        check("s2_ready", bad_ready, 0);
        check("s2_ngrant", grants.size(), 8);
        for (int i = 0; i < grants.size(); i++) begin
            check("s2_grant_seq", grants[i], (i % 2 == 0) ? 1 : 0);
        end
        check("s2_frames", 32'(o_frame_cnt), 9);

        // Short frame from source 1: 10 data beats then 6 zero pads.
        run(0, 16, 1, 10, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("s3_grant", (grants.size() > 0) ? grants[0] : -1, 1);
        check("s3_beats", beat_cnt, 16);
        check("s3_tlast", tlast_cnt, 1);
        check("s3_err", err_cnt, 1);
        check("s3_ready", bad_ready, 0);
        check("s3_frames", 32'(o_frame_cnt), 10);

        // Long frame from source 0: 16 forwarded, 4 drained.
        run(1, 20, 0, 16, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("s4_grant", (grants.size() > 0) ? grants[0] : -1, 0);
        check("s4_beats", beat_cnt, 16);
        check("s4_err", err_cnt, 1);
        check("s4_drain", drain_cnt, 4);
        check("s4_cfg", cfg_cnt, 1);
        check("s4_frames", 32'(o_frame_cnt), 11);

        // Half-rate clock enable with stalling core ready.
        run(1, 16, 0, 16, 1'b1, 1'b0, 1'b1, 1'b1, 0);
        check("s5_cfg", cfg_cnt, 1);
        check("s5_beats", beat_cnt, 16);
        check("s5_tlast", tlast_cnt, 1);
        check("s5_err", err_cnt, 0);
        check("s5_ready", bad_ready, 0);
        check("s5_grant", (grants.size() > 0) ? grants[0] : -1, 0);
        check("s5_frames", 32'(o_frame_cnt), 12);

        // Reset in the middle of an IFFT frame from source 1, with clock enable low.
        run(0, 16, 1, 16, 1'b0, 1'b0, 1'b0, 1'b0, 7);
        check("s6_beats", beat_cnt, 7);
        check("s6_busy", 32'(o_busy), 1);
        check("s6_grant", 32'(o_grant_id), 1);
        check("s6_mode", 32'(o_axi4s_cfg_tdata), 0);
        i_areset = 1'b1;
        i_aclken = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("s6_rst");
        i_areset = 1'b0;

        // After reset the pointer is 0 again: source 0 first, then source 1.
        run(1, 16, 1, 16, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("s7_cfg", cfg_cnt, 2);
        check("s7_beats", beat_cnt, 32);
        check("s7_err", err_cnt, 0);
        check("s7_ngrant", grants.size(), 2);
        check("s7_grant0", (grants.size() > 0) ? grants[0] : -1, 0);
        check("s7_grant1", (grants.size() > 1) ? grants[1] : -1, 1);
        check("s7_frames", 32'(o_frame_cnt), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
